// File: rtl/servo_position_ctrl_if.sv
// Button pulses in, frame-latched pulse width, strobe and status out.
// The master side drives the buttons; the slave side is the controller.
interface servo_position_ctrl_if;
  logic        BC;
  logic        BL;
  logic        BR;
  logic [11:0] PW_OUT;
  logic        FRAME;
  logic        BUSY;
  logic [2:0]  LEDS;

  modport master (
    output BC, BL, BR,
    input  PW_OUT, FRAME, BUSY, LEDS
  );

  modport slave (
    input  BC, BL, BR,
    output PW_OUT, FRAME, BUSY, LEDS
  );
endinterface

// File: rtl/servo_position_ctrl.sv
// Servo position controller: button-stepped target, slew-limited ramp, frame-latched width.
// Target valid 1 cycle after a pulse, ramp 1 us per SLEW_DIV clocks; no backpressure.
module servo_position_ctrl #(
  parameter int PW_MIN     = 900,
  parameter int PW_MAX     = 2100,
  parameter int PW_CENTER  = 1500,
  parameter int STEP       = 100,
  parameter int SLEW_DIV   = 100,
  parameter int FRAME_CLKS = 1_000_000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  servo_position_ctrl_if.slave  sif
);

  localparam int PRE_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam int FC_W  = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;

  localparam logic [11:0]      PW_MIN12  = 12'(PW_MIN);
  localparam logic [11:0]      PW_MAX12  = 12'(PW_MAX);
  localparam logic [11:0]      PW_CEN12  = 12'(PW_CENTER);
  localparam logic [12:0]      PW_MIN13  = 13'(PW_MIN);
  localparam logic [12:0]      PW_MAX13  = 13'(PW_MAX);
  localparam logic [12:0]      STEP13    = 13'(STEP);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SLEW_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(FRAME_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

  logic [11:0]      tgt_q, tgt_d;
  logic [11:0]      pw_q, pw_d;
  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [11:0]      pw_out_q, pw_out_d;
  logic             busy_q, busy_d;

  logic [12:0]      tgt_inc;
  logic [12:0]      tgt_dec;
  logic             pre_wrap;
  logic             frame_now;

  // Saturation is decided on the 13-bit result so neither direction can wrap.
  always_comb begin
    tgt_inc = {1'b0, tgt_q} + STEP13;
    tgt_dec = {1'b0, tgt_q} - STEP13;
    tgt_d   = tgt_q;
    if (sif.BC) begin
      tgt_d = PW_CEN12;
    end else if (sif.BL && !sif.BR) begin
      tgt_d = (tgt_dec[12] || (tgt_dec < PW_MIN13)) ? PW_MIN12 : tgt_dec[11:0];
    end else if (sif.BR && !sif.BL) begin
      tgt_d = (tgt_inc > PW_MAX13) ? PW_MAX12 : tgt_inc[11:0];
    end
  end

  // Steps head toward the freshly updated target, so a retarget mid-ramp never overshoots.
  always_comb begin
    pre_wrap = (state_q != ST_IDLE) && (pre_q == PRE_LAST);
    pw_d     = pw_q;
    state_d  = ST_IDLE;
    pre_d    = '0;
    busy_d   = 1'b0;

    if (pre_wrap) begin
      if (pw_q < tgt_d) begin
        pw_d = pw_q + 12'd1;
      end else if (pw_q > tgt_d) begin
        pw_d = pw_q - 12'd1;
      end
    end

    if (pw_d < tgt_d) begin
      state_d = ST_UP;
    end else if (pw_d > tgt_d) begin
      state_d = ST_DOWN;
    end

    // Leaving IDLE starts from zero; an UP<->DOWN swap keeps counting.
    if ((state_q != ST_IDLE) && (state_d != ST_IDLE) && !pre_wrap) begin
      pre_d = pre_q + 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    frame_now = (fcnt_q == FC_LAST);
    fcnt_d    = frame_now ? '0 : fcnt_q + 1'b1;
    pw_out_d  = frame_now ? pw_q : pw_out_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tgt_q    <= PW_CEN12;
      pw_q     <= PW_CEN12;
      state_q  <= ST_IDLE;
      pre_q    <= '0;
      fcnt_q   <= '0;
      pw_out_q <= PW_CEN12;
      busy_q   <= 1'b0;
    end else begin
      tgt_q    <= tgt_d;
      pw_q     <= pw_d;
      state_q  <= state_d;
      pre_q    <= pre_d;
      fcnt_q   <= fcnt_d;
      pw_out_q <= pw_out_d;
      busy_q   <= busy_d;
    end
  end

  assign sif.PW_OUT = pw_out_q;
  assign sif.FRAME  = frame_now;
  assign sif.BUSY   = busy_q;
  assign sif.LEDS   = {pw_out_q == PW_MAX12, pw_out_q == PW_CEN12, pw_out_q == PW_MIN12};

endmodule
